seven_segment_scanner: RTL and testbench

//  Time-multiplexed driver for a NUM_DIGITS-digit 7-segment display.

---
 rtl/seven_segment_scanner_if.sv | 24 ++
 rtl/seven_segment_scanner.sv | 134 +++++++++++++
 tb/tb_seven_segment_scanner.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scanner_if.sv
// Digit-data load handshake and scanned display lines of the 7-segment scanner.
// The driver (master) writes patterns; the scanner (slave) drives the display.
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [7*NUM_DIGITS-1:0] seg_in;
  logic [NUM_DIGITS-1:0]   neg_in;
  logic                    ready;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_done;

  modport master (
    output load, seg_in, neg_in,
    input  ready, seg_out, dp_out, digit_sel, frame_done
  );

  modport slave (
    input  load, seg_in, neg_in,
    output ready, seg_out, dp_out, digit_sel, frame_done
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Double-buffered, gap-blanked multiplexed scanner for a 7-segment display.
// Define SEG_ACTIVE_LOW_EN for common-anode boards (inverted output lines).
module seven_segment_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int GAP        = 16
) (
  input logic                   clk,
  input logic                   reset,
  seven_segment_scanner_if.slave bus
);

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = 7 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1) begin : g_nd_chk
    $error("NUM_DIGITS must be >= 1");
  end
  if (PRESCALE < 2) begin : g_ps_chk
    $error("PRESCALE must be >= 2");
  end
  if (GAP < 0 || GAP >= PRESCALE) begin : g_gap_chk
    $error("GAP must be in [0, PRESCALE-1]");
  end

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_n;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_n;
  logic [SW-1:0]         act_seg;
  logic [SW-1:0]         act_seg_n;
  logic [SW-1:0]         pend_seg;
  logic [NUM_DIGITS-1:0] act_neg;
  logic [NUM_DIGITS-1:0] act_neg_n;
  logic [NUM_DIGITS-1:0] pend_neg;
  logic                  pend_valid;

  logic                  wrap;
  logic                  frame_end;
  logic                  accept;
  logic                  drive_n;
  logic [6:0]            seg_n;
  logic                  dp_n;
  logic [NUM_DIGITS-1:0] sel_n;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic                  fd_q;

  always_comb begin
    wrap      = (cnt == CNT_LAST);
    frame_end = wrap && (idx == IDX_LAST);
    accept    = bus.load && !pend_valid;

    cnt_n = wrap ? '0 : cnt + CW'(1);
    idx_n = idx;
    if (wrap) begin
      idx_n = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end

    // Active buffer only changes on the frame wrap, so a frame never tears.
    act_seg_n = act_seg;
    act_neg_n = act_neg;
    if (frame_end) begin
      if (pend_valid) begin
        act_seg_n = pend_seg;
        act_neg_n = pend_neg;
      end else if (accept) begin
        act_seg_n = bus.seg_in;
        act_neg_n = bus.neg_in;
      end
    end

    // Outputs are decoded from next state so they line up with cnt.
    drive_n = (32'(cnt_n) >= 32'(GAP));
    sel_n   = '0;
    seg_n   = '0;
    dp_n    = 1'b0;
    if (drive_n) begin
      sel_n = NUM_DIGITS'(1) << idx_n;
      seg_n = act_seg_n[7*int'(idx_n) +: 7];
      dp_n  = act_neg_n[idx_n];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      act_seg    <= '0;
      act_neg    <= '0;
      pend_seg   <= '0;
      pend_neg   <= '0;
      pend_valid <= 1'b0;
      seg_q      <= {7{INV}};
      dp_q       <= INV;
      sel_q      <= {NUM_DIGITS{INV}};
      fd_q       <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      idx     <= idx_n;
      act_seg <= act_seg_n;
      act_neg <= act_neg_n;
      if (accept && !frame_end) begin
        pend_seg   <= bus.seg_in;
        pend_neg   <= bus.neg_in;
        pend_valid <= 1'b1;
      end else if (frame_end) begin
        pend_valid <= 1'b0;
      end
      seg_q <= seg_n ^ {7{INV}};
      dp_q  <= dp_n ^ INV;
      sel_q <= sel_n ^ {NUM_DIGITS{INV}};
      fd_q  <= frame_end;
    end
  end

  assign bus.ready      = !pend_valid;
  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner (4 digits, 8-cycle slots, 2-cycle gap).
// Cycle 0 is the period right after the last reset edge.
module tb_seven_segment_scanner;
  localparam int ND = 4;
  localparam int PS = 8;
  localparam int GP = 2;

`ifdef SEG_ACTIVE_LOW_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  localparam logic [27:0] DA = {7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110};
  localparam logic [3:0]  NA = 4'b0010;
  localparam logic [27:0] DB = {7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000};
  localparam logic [3:0]  NB = 4'b1101;

  typedef struct {
    int         c;
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       rdy;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nmis = 0;
  exp_t q[$];

  seven_segment_scanner_if #(.NUM_DIGITS(ND)) bus ();

  seven_segment_scanner #(
    .NUM_DIGITS(ND),
    .PRESCALE(PS),
    .GAP(GP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Expected display state at cycle c, when data DA becomes visible
  // from cycle 'from' and ready is low over [lo, hi].
  function automatic exp_t mk(int c, int from, int lo, int hi);
    exp_t e;
    logic [27:0] dat;
    logic [3:0] ng;
    int ph;
    int d;
    bit drv;
    dat = DA;
    ng = NA;
    ph = c % PS;
    d = (c / PS) % ND;
    drv = (ph >= GP);
    e.c = c;
    e.sel = drv ? 4'(1 << d) : 4'b0000;
    e.seg = (drv && c >= from) ? dat[7*d +: 7] : 7'b0000000;
    e.dp = (drv && c >= from) ? ng[d] : 1'b0;
    e.rdy = !(c >= lo && c <= hi);
    e.fd = (c > 0) && (c % (PS * ND) == 0);
    e.sel = e.sel ^ {4{INV}};
    e.seg = e.seg ^ {7{INV}};
    e.dp = e.dp ^ INV;
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      if (q[0].c < cyc) begin
        nvec++;
        nmis++;
        $display("FAIL missed c=%0d: vector never presented (now at cycle %0d)",
                 q[0].c, cyc);
        q.delete(0);
      end else if (q[0].c == cyc) begin
        e = q.pop_front();
        nvec++;
        if (bus.digit_sel !== e.sel || bus.seg_out !== e.seg ||
            bus.dp_out !== e.dp || bus.ready !== e.rdy ||
            bus.frame_done !== e.fd) begin
          nmis++;
          $display("FAIL cycle%0d got sel=%b seg=%b dp=%b rdy=%b fd=%b required sel=%b seg=%b dp=%b rdy=%b fd=%b",
                   e.c, bus.digit_sel, bus.seg_out, bus.dp_out, bus.ready,
                   bus.frame_done, e.sel, e.seg, e.dp, e.rdy, e.fd);
        end
      end
    end
  end

  task automatic run_to(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_at(int c, logic [27:0] s, logic [3:0] n);
    run_to(c);
    bus.load = 1'b1;
    bus.seg_in = s;
    bus.neg_in = n;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  task automatic push_range(int a, int b, int from, int lo, int hi);
    for (int c = a; c <= b; c++) q.push_back(mk(c, from, lo, hi));
  endtask

  task automatic do_reset();
    exp_t e;
    reset = 1'b1;
    @(posedge clk);
    #1;
    e.c = 0;
    e.sel = {4{INV}};
    e.seg = {7{INV}};
    e.dp = INV;
    e.rdy = 1'b1;
    e.fd = 1'b0;
    q.push_back(e);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(string tag);
    nvec++;
    if (q.size() != 0) begin
      nmis++;
      $display("FAIL %s drain: %0d vectors unmatched, required 0", tag, q.size());
      q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load = 1'b0;
    bus.seg_in = '0;
    bus.neg_in = '0;

    // Scan timing, buffered load, ignored load while busy, frame_done.
    do_reset();
    push_range(0, 103, 32, 6, 31);
    load_at(5, DA, NA);
    load_at(10, DB, NB);
    run_to(104);
    drain("scan");

    // Load on the frame-end cycle bypasses the pending buffer.
    do_reset();
    push_range(0, 63, 32, 1000, 1000);
    load_at(31, DA, NA);
    run_to(64);
    drain("frame_end_load");

    // Mid-frame reset discards pending data.
    do_reset();
    push_range(0, 20, 1000, 6, 20);
    load_at(5, DA, NA);
    run_to(20);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_range(0, 63, 1000, 1000, 1000);
    run_to(64);
    drain("mid_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
